// File: rtl/franken_dmem_responder_if.sv
// Data-side bus between the franken_riscv core and its memory responder,
// including the console TX byte stream.
interface franken_dmem_responder_if;
  logic        mem_write;
  logic [3:0]  byte_enable;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  mem_write, byte_enable, alu_result, write_data, tx_ready,
    output read_data, tx_data, tx_valid
  );

  modport master (
    output mem_write, byte_enable, alu_result, write_data, tx_ready,
    input  read_data, tx_data, tx_valid
  );
endinterface

// File: rtl/franken_dmem_responder.sv
// Data memory responder: byte-writable RAM plus an MMIO window with a console
// TX FIFO, a status register and a 64-bit cycle snapshot. Loads are combinational.
module franken_dmem_responder #(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  franken_dmem_responder_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SEL_TX      = 2'd0,
    SEL_STATUS  = 2'd1,
    SEL_SNAP_LO = 2'd2,
    SEL_SNAP_HI = 2'd3
  } mmio_sel_e;

  function automatic logic [31:0] status_word(input logic [CNT_W-1:0] cnt,
                                              input logic o, input logic f,
                                              input logic e);
    return {24'b0, 4'(cnt), 1'b0, o, f, e};
  endfunction

  logic              ram_hit;
  logic              mmio_hit;
  mmio_sel_e         sel;
  logic [RAM_AW-1:0] word_idx;
  logic              unused_addr;

  assign ram_hit     = (bus.alu_result[31:28] == 4'h0);
  assign mmio_hit    = (bus.alu_result[31:28] == 4'hF);
  assign sel         = mmio_sel_e'(bus.alu_result[3:2]);
  assign word_idx    = bus.alu_result[RAM_AW+1:2];
  // Upper RAM address bits alias; the byte offset is carried by byte_enable.
  assign unused_addr = ^{bus.alu_result[27:RAM_AW+2], bus.alu_result[1:0]};

  logic [31:0] ram [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (bus.mem_write && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byte_enable[i]) ram[word_idx][8*i +: 8] <= bus.write_data[8*i +: 8];
      end
    end
  end

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [63:0]      cycle;
  logic [63:0]      snap;

  logic empty, full, push_req, pop, push_ok, ovf_set, ovf_clr, snap_ld;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign pop      = !empty && bus.tx_ready;
  assign push_req = bus.mem_write && mmio_hit && (sel == SEL_TX) && bus.byte_enable[0];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = bus.mem_write && mmio_hit && (sel == SEL_STATUS) &&
                    bus.byte_enable[0] && bus.write_data[2];
  assign snap_ld  = bus.mem_write && mmio_hit && (sel == SEL_SNAP_LO);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.write_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      cycle  <= 64'd0;
      snap   <= 64'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      cycle <= cycle + 64'd1;
      if (snap_ld) snap <= cycle;
    end
  end

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  always_comb begin
    bus.read_data = 32'h0;
    if (ram_hit) begin
      bus.read_data = ram[word_idx];
    end else if (mmio_hit) begin
      case (sel)
        SEL_STATUS:  bus.read_data = status_word(count, ovf, full, empty);
        SEL_SNAP_LO: bus.read_data = snap[31:0];
        SEL_SNAP_HI: bus.read_data = snap[63:32];
        default:     bus.read_data = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_franken_dmem_responder.sv
// Self-checking bench for franken_dmem_responder: directed scenarios plus a
// randomized run against a queue/array reference model.
module tb_franken_dmem_responder;
  localparam int RAM_AW = 10;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  franken_dmem_responder_if bus();

  franken_dmem_responder #(.RAM_AW(RAM_AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [7:0]  q [$];
  logic        ovf_m;
  logic [63:0] cyc_m;
  logic [63:0] snap_m;

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int k;
    logic [31:0] st;
    if (a[31:28] == 4'h0) begin
      k = int'(a[RAM_AW+1:2]);
      if (ram_m.exists(k)) return ram_m[k];
      return 32'hxxxx_xxxx;
    end
    if (a[31:28] != 4'hF) return 32'h0;
    st = {24'b0, 4'(q.size()), 1'b0, ovf_m, (q.size() == DEPTH), (q.size() == 0)};
    case (a[3:2])
      2'd1:    return st;
      2'd2:    return snap_m[31:0];
      2'd3:    return snap_m[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] exp_tx();
    if (q.size() == 0) return 8'h00;
    return q[0];
  endfunction

  task automatic drive(input logic mw, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.mem_write   = mw;
    bus.byte_enable = be;
    bus.alu_result  = a;
    bus.write_data  = wd;
  endtask

  // Advance one clock, applying the inputs present at the edge to the model.
  task automatic tick();
    logic push, pop, full_b, mmio;
    logic [31:0] w;
    int k;
    @(posedge clk);
    if (!reset) begin
      mmio   = (bus.alu_result[31:28] == 4'hF);
      full_b = (q.size() == DEPTH);
      pop    = (q.size() > 0) && bus.tx_ready;
      push   = bus.mem_write && mmio && (bus.alu_result[3:2] == 2'd0) && bus.byte_enable[0];
      if (bus.mem_write && bus.alu_result[31:28] == 4'h0) begin
        k = int'(bus.alu_result[RAM_AW+1:2]);
        w = ram_m.exists(k) ? ram_m[k] : 32'hxxxx_xxxx;
        for (int i = 0; i < 4; i++)
          if (bus.byte_enable[i]) w[8*i +: 8] = bus.write_data[8*i +: 8];
        ram_m[k] = w;
      end
      if (bus.mem_write && mmio && bus.alu_result[3:2] == 2'd1 && bus.byte_enable[0] &&
          bus.write_data[2]) ovf_m = 1'b0;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (!full_b || pop) q.push_back(bus.write_data[7:0]);
        else ovf_m = 1'b1;
      end
      if (bus.mem_write && mmio && bus.alu_result[3:2] == 2'd2) snap_m = cyc_m;
      cyc_m = cyc_m + 64'd1;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m  = 1'b0;
    cyc_m  = 64'd0;
    snap_m = 64'd0;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); else passed++;
    checks++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else passed++;
    bus.alu_result = 32'hF000_0004; #1;
    checks++; if (bus.read_data !== 32'h1) $display("FAIL reset_status: got %h want 00000001", bus.read_data); else passed++;
    bus.alu_result = 32'hF000_0008; #1;
    checks++; if (bus.read_data !== 32'h0) $display("FAIL reset_snap_lo: got %h want 0", bus.read_data); else passed++;
    bus.alu_result = 32'hF000_000C; #1;
    checks++; if (bus.read_data !== 32'h0) $display("FAIL reset_snap_hi: got %h want 0", bus.read_data); else passed++;
    tick();
  endtask

  task automatic test_ram();
    drive(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 4'h0, 32'h0000_0100, 32'h0); #1;
    checks++; if (bus.read_data !== 32'hDEAD_BEEF) $display("FAIL ram_sw: got %h want deadbeef", bus.read_data); else passed++;
    drive(1'b1, 4'b0100, 32'h0000_0102, 32'h005A_0000); #1;
    checks++; if (bus.read_data !== 32'hDEAD_BEEF) $display("FAIL ram_same_cycle_old: got %h want deadbeef", bus.read_data); else passed++;
    tick();
    drive(1'b0, 4'h0, 32'h0000_0100, 32'h0); #1;
    checks++; if (bus.read_data !== 32'hDE5A_BEEF) $display("FAIL ram_sb: got %h want de5abeef", bus.read_data); else passed++;
    drive(1'b1, 4'b0100, 32'h1000_0100, 32'h0077_0000); #1;
    checks++; if (bus.read_data !== 32'h0) $display("FAIL unmapped_read: got %h want 0", bus.read_data); else passed++;
    tick();
    drive(1'b0, 4'h0, 32'h0000_0100, 32'h0); #1;
    checks++; if (bus.read_data !== 32'hDE5A_BEEF) $display("FAIL unmapped_store_ignored: got %h want de5abeef", bus.read_data); else passed++;
    bus.alu_result = 32'h0000_1100; #1;
    checks++; if (bus.read_data !== 32'hDE5A_BEEF) $display("FAIL ram_alias: got %h want de5abeef", bus.read_data); else passed++;
    tick();
  endtask

  task automatic test_fifo_overflow();
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 4'b0001, 32'hF000_0000, 32'(i));
      #1;
      checks++; if (bus.tx_valid !== (q.size() > 0)) $display("FAIL push_latency[%0d]: got %b want %b", i, bus.tx_valid, q.size() > 0); else passed++;
      tick();
    end
    drive(1'b0, 4'h0, 32'hF000_0004, 32'h0); #1;
    checks++; if (bus.read_data !== 32'h86) $display("FAIL ovf_status: got %h want 00000086", bus.read_data); else passed++;
    checks++; if (bus.tx_data !== 8'h01) $display("FAIL ovf_head: got %h want 01", bus.tx_data); else passed++;
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(i)) $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.tx_valid, bus.tx_data, 8'(i)); else passed++;
      tick();
    end
    #1;
    checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) $display("FAIL drained_empty: got v=%b d=%h want v=0 d=00", bus.tx_valid, bus.tx_data); else passed++;
    checks++; if (bus.read_data !== 32'h05) $display("FAIL drained_status: got %h want 00000005", bus.read_data); else passed++;
    bus.tx_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'hF000_0004, 32'h4);
    tick();
    drive(1'b0, 4'h0, 32'hF000_0004, 32'h0); #1;
    checks++; if (bus.read_data !== 32'h01) $display("FAIL ovf_clear: got %h want 00000001", bus.read_data); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] e;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'b0001, 32'hF000_0000, 32'h11 + 32'(i));
      tick();
    end
    drive(1'b1, 4'b0001, 32'hF000_0000, 32'hAA);
    bus.tx_ready = 1'b1; #1;
    checks++; if (bus.tx_data !== 8'h11) $display("FAIL full_head: got %h want 11", bus.tx_data); else passed++;
    tick();
    bus.tx_ready = 1'b0;
    drive(1'b0, 4'h0, 32'hF000_0004, 32'h0); #1;
    checks++; if (bus.read_data !== 32'h82) $display("FAIL full_pushpop_status: got %h want 00000082", bus.read_data); else passed++;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = (i < 7) ? 8'(8'h12 + i) : 8'hAA;
      #1;
      checks++; if (bus.tx_data !== e || bus.tx_data !== exp_tx()) $display("FAIL full_drain[%0d]: got %h want %h", i, bus.tx_data, e); else passed++;
      tick();
    end
    bus.tx_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'hF000_0000, 32'h33);
    tick();
    drive(1'b1, 4'b0001, 32'hF000_0000, 32'h44);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    drive(1'b0, 4'h0, 32'hF000_0004, 32'h0); #1;
    checks++; if (bus.tx_data !== 8'h44 || bus.tx_valid !== 1'b1) $display("FAIL one_pushpop_head: got v=%b d=%h want v=1 d=44", bus.tx_valid, bus.tx_data); else passed++;
    checks++; if (bus.read_data !== 32'h10) $display("FAIL one_pushpop_status: got %h want 00000010", bus.read_data); else passed++;
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_snap();
    do_reset();
    while (cyc_m != 64'd100) tick();
    drive(1'b1, 4'hF, 32'hF000_0008, $urandom);
    tick();
    drive(1'b0, 4'h0, 32'hF000_0008, 32'h0); #1;
    checks++; if (bus.read_data !== 32'd100) $display("FAIL snap_lo_100: got %0d want 100", bus.read_data); else passed++;
    bus.alu_result = 32'hF000_000C; #1;
    checks++; if (bus.read_data !== 32'd0) $display("FAIL snap_hi_100: got %h want 0", bus.read_data); else passed++;
    drive(1'b1, 4'hF, 32'hF000_000C, 32'h1234_5678);
    tick();
    drive(1'b0, 4'h0, 32'hF000_0008, 32'h0); #1;
    checks++; if (bus.read_data !== 32'd100) $display("FAIL snap_hi_store_ignored: got %0d want 100", bus.read_data); else passed++;
    force dut.cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle;
    cyc_m = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1'b1, 4'hF, 32'hF000_0008, 32'h0);
    tick();
    drive(1'b0, 4'h0, 32'hF000_0008, 32'h0); #1;
    checks++; if (bus.read_data !== 32'hFFFF_FFFF) $display("FAIL snap_lo_ones: got %h want ffffffff", bus.read_data); else passed++;
    bus.alu_result = 32'hF000_000C; #1;
    checks++; if (bus.read_data !== 32'hFFFF_FFFF) $display("FAIL snap_hi_ones: got %h want ffffffff", bus.read_data); else passed++;
    drive(1'b1, 4'hF, 32'hF000_0008, 32'h0);
    tick();
    drive(1'b0, 4'h0, 32'hF000_0008, 32'h0); #1;
    checks++; if (bus.read_data !== 32'h0) $display("FAIL snap_lo_wrap: got %h want 0", bus.read_data); else passed++;
    bus.alu_result = 32'hF000_000C; #1;
    checks++; if (bus.read_data !== 32'h0) $display("FAIL snap_hi_wrap: got %h want 0", bus.read_data); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0001, 32'hF000_0000, 32'hA1 + 32'(i));
      tick();
    end
    drive(1'b0, 4'h0, 32'hF000_0004, 32'h0); #1;
    checks++; if (bus.tx_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", bus.tx_valid); else passed++;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) $display("FAIL async_reset_out: got v=%b d=%h want v=0 d=00", bus.tx_valid, bus.tx_data); else passed++;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.read_data !== 32'h01) $display("FAIL post_reset_status: got %h want 00000001", bus.read_data); else passed++;
    bus.alu_result = 32'h0000_0100; #1;
    checks++; if (bus.read_data !== 32'hDE5A_BEEF) $display("FAIL ram_survives_reset: got %h want de5abeef", bus.read_data); else passed++;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] r, a, e, wd;
    logic [3:0]  be;
    int kind;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'hF, 32'(k * 4), $urandom);
      tick();
    end
    for (int n = 0; n < 400; n++) begin
      r    = $urandom;
      wd   = $urandom;
      kind = $urandom_range(0, 9);
      if (kind < 4)      a = {4'h0, r[27:12], 6'b0, r[5:2], r[1:0]};
      else if (kind < 6) a = {4'hF, r[27:4], 2'd0, 2'b00};
      else if (kind < 9) a = {4'hF, r[27:4], r[3:2], 2'b00};
      else               a = {4'(1 + (r[31:28] % 14)), r[27:0]};
      be = (r[8]) ? 4'hF : (4'b0001 << r[10:9]);
      drive((kind < 6) ? r[11] | r[12] : r[11], be, a, wd);
      bus.tx_ready = ($urandom_range(0, 9) < 3);
      #1;
      e = exp_read(a);
      if (!$isunknown(e)) begin
        checks++; if (bus.read_data !== e) $display("FAIL rand_read[%0d] addr %h: got %h want %h", n, a, bus.read_data, e); else passed++;
      end
      checks++; if (bus.tx_valid !== (q.size() > 0) || bus.tx_data !== exp_tx()) $display("FAIL rand_tx[%0d]: got v=%b d=%h want v=%b d=%h", n, bus.tx_valid, bus.tx_data, q.size() > 0, exp_tx()); else passed++;
      tick();
    end
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.tx_ready = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    model_reset();
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_full_push_pop();
    test_snap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
